// File: rtl/dem_sv_checker_pkg.sv
// Shared constants and FSM encoding for the DEM selection-vector checker.
package dem_sv_checker_pkg;

  localparam int                N_ELEM   = 18;
  localparam logic [5:0]        V_OFFSET = 6'd9;
  localparam logic signed [5:0] V_MIN    = -6'sd9;
  localparam logic signed [5:0] V_MAX    = 6'sd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/dem_popcnt18.sv
// Combinational ones counter for an 18-bit element selection vector.
module dem_popcnt18 (
  input  logic [17:0] vec,
  output logic [4:0]  cnt
);

  // Sum the selected elements.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each partial sum is visible to the next iteration.
    cnt = '0;
    for (int i = 0; i < 18; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
  end

endmodule

// File: rtl/dem_sv_checker.sv
// Receive-side checker: decodes SV back to a code, compares it against the
// delayed input code, and measures per-element usage spread over a window.
module dem_sv_checker
  import dem_sv_checker_pkg::*;
#(
  parameter int V_DLY = 1,
  parameter int WIN   = 1024,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [17:0]   SV,
  input  logic [5:0]    V,
  input  logic          start,
  output logic [5:0]    Vdec,
  output logic          dec_valid,
  output logic          err,
  output logic          range_err,
  output logic [15:0]   err_cnt,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] spread,
  input  logic          rd_req,
  input  logic [4:0]    rd_idx,
  output logic          rd_valid,
  output logic [CW-1:0] rd_data
);

  localparam logic [15:0] WIN_C = 16'(WIN);

  state_t              state, state_nxt;
  logic [17:0]         sv_q;
  logic signed [5:0]   v_ref;
  logic signed [5:0]   v_tap;
  logic                s1_valid;
  logic [4:0]          pc;
  logic [5:0]          vdec_n;
  logic                range_n;
  logic                err_n;
  logic                count_ev;
  logic                last_sample;
  logic                scan_last;
  logic [15:0]         sample_cnt;
  logic [4:0]          scan_idx;
  logic [CW-1:0]       cnt [N_ELEM];
  logic [CW-1:0]       mx, mn, cur, mx_n, mn_n;

  // V delay line: aligns the input code with the SV it produced, advancing only on en.
  if (V_DLY == 0) begin : g_nodly
    assign v_tap = V;
  end else begin : g_dly
    logic [5:0] dline [V_DLY];

    // Shift V through V_DLY stages on each accepted sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < V_DLY; i++) dline[i] <= '0;
      end else if (en) begin
        dline[0] <= V;
        for (int i = 1; i < V_DLY; i++) dline[i] <= dline[i-1];
      end
    end

    assign v_tap = dline[V_DLY-1];
  end

  // Stage 1: capture SV and the aligned reference code.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    if (rst) begin
      sv_q     <= '0;
      v_ref    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= en;
      if (en) begin
        sv_q  <= SV;
        v_ref <= v_tap;
      end
    end
  end

  dem_popcnt18 u_popcnt (
    .vec (sv_q),
    .cnt (pc)
  );

  assign vdec_n      = {1'b0, pc} - V_OFFSET;
  assign range_n     = (v_ref < V_MIN) || (v_ref > V_MAX);
  assign err_n       = (vdec_n != v_ref) || range_n;
  assign count_ev    = s1_valid && (state == RUN) && !start;
  assign last_sample = count_ev && (sample_cnt == WIN_C - 16'd1);
  assign scan_last   = (state == SCAN) && (scan_idx == 5'(N_ELEM - 1));

  // Stage 2: register the decode result; outputs read zero between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid <= 1'b0;
      Vdec      <= '0;
      err       <= 1'b0;
      range_err <= 1'b0;
    end else begin
      dec_valid <= s1_valid;
      Vdec      <= s1_valid ? vdec_n : '0;
      err       <= s1_valid && err_n;
      range_err <= s1_valid && range_n;
    end
  end

  // Saturating error counter, active in every state, cleared by start.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      err_cnt <= '0;
    end else if (s1_valid && err_n && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  // Per-element usage counters, incremented only while a window is running.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is reset explicitly because its contents are directly observable.
    if (rst || start) begin
      for (int i = 0; i < N_ELEM; i++) cnt[i] <= '0;
    end else if (count_ev) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (sv_q[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Running max/min including the element visited this cycle.
  always_comb begin
    cur  = cnt[scan_idx];
    mx_n = cur;
    mn_n = cur;
    if (scan_idx != '0) begin
      if (mx > cur) mx_n = mx;
      if (mn < cur) mn_n = mn;
    end
  end

  // Window sample counter and usage scan.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_cnt <= '0;
      scan_idx   <= '0;
      mx         <= '0;
      mn         <= '0;
      spread     <= '0;
    end else begin
      if (count_ev) sample_cnt <= sample_cnt + 16'd1;
      if (state == SCAN) begin
        mx       <= mx_n;
        mn       <= mn_n;
        scan_idx <= scan_last ? 5'd0 : scan_idx + 5'd1;
        if (scan_last) spread <= mx_n - mn_n;
      end
    end
  end

  // Indexed read port; returns the value held before any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= (rd_req && (rd_idx < 5'(N_ELEM))) ? cnt[rd_idx] : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; start restarts a window from any state.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (last_sample) state_nxt = SCAN;
        SCAN:    if (scan_last)   state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state == RUN) || (state == SCAN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_dem_sv_checker.sv
// Self-checking bench for dem_sv_checker with a behavioural reference model.
module tb_dem_sv_checker;

  localparam int WIN = 36;
  localparam int NE  = 18;

  logic        clk = 1'b0;
  logic        rst, en, start, rd_req;
  logic [17:0] SV;
  logic [5:0]  V;
  logic [4:0]  rd_idx;
  logic [5:0]  Vdec;
  logic        dec_valid, err, range_err, busy, done, rd_valid;
  logic [15:0] err_cnt, spread, rd_data;

  dem_sv_checker #(.V_DLY(1), .WIN(WIN), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .SV(SV), .V(V), .start(start),
    .Vdec(Vdec), .dec_valid(dec_valid), .err(err), .range_err(range_err),
    .err_cnt(err_cnt), .busy(busy), .done(done), .spread(spread),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending sample, code history, usage counts, window progress.
  bit          p_valid;
  logic [17:0] p_sv;
  int          p_vref, prev_v, m_errcnt, n_samp;
  int          use_cnt [NE];
  bit          counting;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [17:0] sv_k(input int p);
    logic [17:0] s = '0;
    while ($countones(s) < p) s[$urandom_range(17, 0)] = 1'b1;
    return s;
  endfunction

  function automatic int model_spread();
    int mx = use_cnt[0];
    int mn = use_cnt[0];
    for (int i = 1; i < NE; i++) begin
      if (use_cnt[i] > mx) mx = use_cnt[i];
      if (use_cnt[i] < mn) mn = use_cnt[i];
    end
    return mx - mn;
  endfunction

  task automatic model_reset();
    p_valid = 0; p_sv = '0; p_vref = 0; prev_v = 0; m_errcnt = 0;
    n_samp = 0; counting = 0;
    for (int i = 0; i < NE; i++) use_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; start = 0; rd_req = 0; SV = '0; V = '0; rd_idx = '0;
    tick();
    model_reset();
    check("rst_dec_valid", dec_valid, 0);
    check("rst_vdec", {26'd0, Vdec}, 0);
    check("rst_err", err, 0);
    check("rst_range_err", range_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spread", spread, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 0;
  endtask

  // One clock of stimulus; the model predicts what this edge produces.
  task automatic step(input bit t_en, input logic [17:0] t_sv, input int t_v,
                      input bit t_start, input bit t_rd, input int t_idx, input bit chk);
    logic [5:0]  e_vdec;
    logic [15:0] e_rd;
    bit          e_dv, e_err, e_rerr;
    int          dec;
    dec    = $countones(p_sv) - 9;
    e_dv   = p_valid;
    e_vdec = p_valid ? 6'(dec) : 6'd0;
    e_rerr = p_valid && (p_vref < -9 || p_vref > 9);
    e_err  = p_valid && ((dec != p_vref) || e_rerr);
    e_rd   = (t_rd && t_idx < NE) ? 16'(use_cnt[t_idx]) : 16'd0;
    if (t_start) m_errcnt = 0;
    else if (e_err && m_errcnt < 65535) m_errcnt++;
    if (t_start) begin
      for (int i = 0; i < NE; i++) use_cnt[i] = 0;
      n_samp = 0;
      counting = 1;
    end else if (counting && p_valid) begin
      for (int i = 0; i < NE; i++) use_cnt[i] += int'(p_sv[i]);
      n_samp++;
      if (n_samp == WIN) counting = 0;
    end
    if (t_en) begin
      p_sv = t_sv;
      p_vref = prev_v;
      prev_v = t_v;
    end
    p_valid = t_en;
    en = t_en; SV = t_sv; V = 6'(t_v); start = t_start; rd_req = t_rd; rd_idx = 5'(t_idx);
    tick();
    if (chk) begin
      check("dec_valid", dec_valid, e_dv);
      check("vdec", {26'd0, Vdec}, {26'd0, e_vdec});
      check("err", err, e_err);
      check("range_err", range_err, e_rerr);
      check("err_cnt", err_cnt, m_errcnt);
      check("rd_valid", rd_valid, t_rd);
      check("rd_data", rd_data, e_rd);
    end
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (done !== 1'b1 && w < 40) begin
      step(0, '0, 0, 0, 0, 0, 1);
      w++;
    end
    check("done_seen", done, 1);
    check("busy_after_done", busy, 0);
    check("spread_model", spread, model_spread());
  endtask

  task automatic read_all();
    for (int i = 0; i < NE; i++) step(0, '0, 0, 0, 1, i, 1);
  endtask

  function automatic int rand_v();
    int r = int'($urandom_range(15, 0));
    if (r == 0) return 10 + int'($urandom_range(4, 0));
    if (r == 1) return -10 - int'($urandom_range(4, 0));
    return int'($urandom_range(18, 0)) - 9;
  endfunction

  function automatic logic [17:0] rand_sv();
    int p;
    if ($urandom_range(9, 0) < 8) begin
      p = prev_v + 9;
      if (p < 0) p = 0;
      if (p > 18) p = 18;
    end else begin
      p = int'($urandom_range(18, 0));
    end
    return sv_k(p);
  endfunction

  initial begin
    int w;
    int guard;
    do_reset();

    // Matched decode: V=+3 with 12 selected elements.
    step(1, sv_k(9), 3, 0, 0, 0, 1);
    repeat (4) step(1, sv_k(12), 3, 0, 0, 0, 1);
    check("vdec_plus3", {26'd0, Vdec}, 6'd3);
    check("no_err", err, 0);
    check("err_cnt_zero", err_cnt, 0);

    // One short vector, then an out-of-range code.
    step(1, sv_k(11), 3, 0, 0, 0, 1);
    step(1, sv_k(12), 12, 0, 0, 0, 1);
    check("err_one", err, 1);
    check("err_cnt_one", err_cnt, 1);
    step(1, sv_k(12), 3, 0, 0, 0, 1);
    step(1, sv_k(12), 3, 0, 0, 0, 1);
    check("range_err_hi", range_err, 1);
    check("range_err_err", err, 1);

    // Randomized decode traffic with random reads while idle.
    for (int k = 0; k < 300; k++) begin
      logic [17:0] s;
      s = rand_sv();
      step($urandom_range(3, 0) != 0, s, rand_v(), 0, $urandom_range(3, 0) == 0,
           int'($urandom_range(31, 0)), 1);
    end

    // Sustained mismatch saturates the error counter.
    for (int k = 0; k < 65540; k++) step(1, '0, 3, 0, 0, 0, 0);
    step(1, '0, 3, 0, 0, 0, 1);
    check("err_cnt_sat", err_cnt, 16'hFFFF);

    // Window A: single element rotating over all 18 positions.
    step(0, '0, 0, 1, 0, 0, 1);
    check("start_busy", busy, 1);
    for (int k = 0; k < WIN; k++) step(1, 18'(1) << (k % NE), -8, 0, 0, 0, 1);
    check("busy_in_window", busy, 1);
    check("no_done_yet", done, 0);
    wait_done(w);
    check("scan_len", w, 19);
    check("spread_rot", spread, 0);
    read_all();
    step(0, '0, 0, 0, 1, 20, 1);
    check("rd_oob", rd_data, 0);

    // Window B: element 5 every sample, with a read on an incrementing edge.
    step(0, '0, 0, 1, 0, 0, 1);
    for (int k = 0; k < WIN; k++) begin
      step(1, 18'(1) << 5, -8, 0, k == 10, 5, 1);
      if (k == 10) check("rd_pre_inc", rd_data, 9);
    end
    wait_done(w);
    check("spread_elem5", spread, 36);
    step(0, '0, 0, 0, 1, 5, 1);
    check("cnt5", rd_data, 36);

    // Window C: random vectors with random en gaps.
    step(0, '0, 0, 1, 0, 0, 1);
    guard = 0;
    while (counting && guard < 300) begin
      logic [17:0] s;
      s = rand_sv();
      step($urandom_range(2, 0) != 0, s, rand_v(), 0, $urandom_range(4, 0) == 0,
           int'($urandom_range(19, 0)), 1);
      guard++;
    end
    check("win_c_filled", counting, 0);
    wait_done(w);
    read_all();

    // Window D: restart in the middle of SCAN.
    step(0, '0, 0, 1, 0, 0, 1);
    for (int k = 0; k < WIN; k++) step(1, rand_sv(), rand_v(), 0, 0, 0, 1);
    repeat (4) step(0, '0, 0, 0, 0, 0, 1);
    check("scan_busy", busy, 1);
    step(0, '0, 0, 1, 0, 0, 1);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_spread", spread, 0);
    step(0, '0, 0, 0, 1, 5, 1);
    check("restart_cleared", rd_data, 0);

    // Reset in the middle of RUN.
    for (int k = 0; k < 5; k++) step(1, rand_sv(), rand_v(), 0, 0, 0, 1);
    check("run_busy", busy, 1);
    do_reset();
    step(0, '0, 0, 0, 0, 0, 1);
    check("idle_after_rst", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
